dma_streamer: RTL and testbench

- Splits one DMA descriptor (start address, byte count) into a sequence of AXI-legal request beats/bursts.
- Drives the AXI interface block's s_dma_axi_req_t port (addr, alen, size, strb, valid) and consumes its ready.
- Two instances per DMA: one for the read side (descriptor source) and one for the write side (descriptor destination).
- The DMA FSM starts both instances and waits for both done_o.

---
 rtl/dma_pkg.sv | 34 +++
 rtl/dma_burst_calc.sv | 68 ++++++
 rtl/dma_streamer.sv | 115 +++++++++++
 tb/tb_dma_streamer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types and constants for the AXI request streamers.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W    = 32;
    localparam int unsigned DMA_DATA_W    = 512;
    localparam int unsigned DMA_BPB       = DMA_DATA_W / 8;
    localparam int unsigned DMA_MAX_BEATS = 16;
    localparam int unsigned DMA_BOUNDARY  = 4096;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            alen;
        logic [2:0]            size;
        logic [DMA_BPB-1:0]    strb;
        logic                  valid;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_ADDR_W-1:0] num_bytes;
    } s_dma_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REQ,
        DONE
    } dma_strm_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: picks the largest AXI-legal request for the
// current address and remaining byte count.
module dma_burst_calc #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BPB       = 64,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned BOUNDARY  = 4096
) (
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [ADDR_W-1:0] remaining,
    output logic [7:0]        alen,
    output logic [2:0]        size,
    output logic [BPB-1:0]    strb,
    output logic [ADDR_W:0]   bytes
);

    localparam int unsigned W       = ADDR_W + 1;
    localparam int unsigned SW      = 2 * BPB;
    localparam int unsigned LOG_BPB = $clog2(BPB);
    localparam logic [W-1:0] BPB_W  = W'(BPB);
    localparam logic [W-1:0] BPB_M  = W'(BPB - 1);
    localparam logic [W-1:0] BND_W  = W'(BOUNDARY);
    localparam logic [W-1:0] BND_M  = W'(BOUNDARY - 1);
    localparam logic [W-1:0] MAXB_W = W'(MAX_BEATS);

    logic [W-1:0] addr_w;
    logic [W-1:0] rem_w;
    logic [W-1:0] rem_beats;
    logic [W-1:0] bnd_beats;
    logic [W-1:0] beats;
    logic [W-1:0] p;
    logic [2:0]   nsize;
    logic         full;

    always_comb begin
        addr_w    = {1'b0, cur_addr};
        rem_w     = {1'b0, remaining};
        full      = ((addr_w & BPB_M) == '0) && (rem_w >= BPB_W);
        rem_beats = rem_w >> LOG_BPB;
        bnd_beats = (BND_W - (addr_w & BND_M)) >> LOG_BPB;

        beats = rem_beats;
        if (MAXB_W < beats)    beats = MAXB_W;
        if (bnd_beats < beats) beats = bnd_beats;

        // Both conditions are monotone in p, so the last hit is the largest.
        nsize = '0;
        for (int unsigned k = 0; k <= LOG_BPB; k++) begin
            if (((W'(1) << k) <= rem_w) &&
                ((addr_w & ((W'(1) << k) - W'(1))) == '0))
                nsize = 3'(k);
        end
        p = W'(1) << nsize;

        if (full) begin
            alen  = 8'(beats - W'(1));
            size  = 3'(LOG_BPB);
            strb  = '1;
            bytes = beats << LOG_BPB;
        end else begin
            alen  = '0;
            size  = nsize;
            strb  = BPB'(((SW'(1) << p) - SW'(1)) << (addr_w & BPB_M));
            bytes = p;
        end
    end

endmodule

// File: rtl/dma_streamer.sv
// Splits one DMA descriptor into a stream of AXI-legal request bursts.
module dma_streamer
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W    = DMA_ADDR_W,
    parameter int unsigned DATA_W    = DMA_DATA_W,
    parameter int unsigned MAX_BEATS = DMA_MAX_BEATS,
    parameter int unsigned BOUNDARY  = DMA_BOUNDARY
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dma_go_i,
    input  logic [ADDR_W-1:0] desc_addr_i,
    input  logic [ADDR_W-1:0] desc_num_bytes_i,
    input  logic            dma_active_i,
    input  logic            clear_dma_i,
    output s_dma_axi_req_t  dma_axi_req_o,
    input  s_dma_axi_resp_t dma_axi_resp_i,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned BPB = DATA_W / 8;

    dma_strm_st_t      state_q, state_d;
    s_dma_desc_t       desc;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [7:0]        alen_q;
    logic [2:0]        size_q;
    logic [BPB-1:0]    strb_q;
    logic [ADDR_W:0]   bytes_q;

    logic [7:0]        calc_alen;
    logic [2:0]        calc_size;
    logic [BPB-1:0]    calc_strb;
    logic [ADDR_W:0]   calc_bytes;
    logic              handshake;

    assign desc      = '{addr: desc_addr_i, num_bytes: desc_num_bytes_i};
    assign handshake = dma_active_i && (state_q == REQ) && dma_axi_resp_i.ready;

    dma_burst_calc #(
        .ADDR_W    (ADDR_W),
        .BPB       (BPB),
        .MAX_BEATS (MAX_BEATS),
        .BOUNDARY  (BOUNDARY)
    ) u_calc (
        .cur_addr  (cur_addr_q),
        .remaining (remaining_q),
        .alen      (calc_alen),
        .size      (calc_size),
        .strb      (calc_strb),
        .bytes     (calc_bytes)
    );

    always_comb begin
        state_d = state_q;
        if (!dma_active_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (dma_go_i)
                          state_d = (desc.num_bytes == '0) ? DONE : CALC;
                CALC: state_d = REQ;
                REQ:  if (dma_axi_resp_i.ready)
                          state_d = ({1'b0, remaining_q} == bytes_q) ? DONE : CALC;
                DONE: if (clear_dma_i)
                          state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            alen_q      <= '0;
            size_q      <= '0;
            strb_q      <= '0;
            bytes_q     <= '0;
        end else begin
            state_q <= state_d;
            if (dma_active_i && state_q == IDLE && dma_go_i) begin
                cur_addr_q  <= desc.addr;
                remaining_q <= desc.num_bytes;
            end
            if (dma_active_i && state_q == CALC) begin
                alen_q  <= calc_alen;
                size_q  <= calc_size;
                strb_q  <= calc_strb;
                bytes_q <= calc_bytes;
            end
            if (handshake) begin
                cur_addr_q  <= cur_addr_q + bytes_q[ADDR_W-1:0];
                remaining_q <= remaining_q - bytes_q[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        dma_axi_req_o       = '0;
        dma_axi_req_o.addr  = cur_addr_q;
        dma_axi_req_o.alen  = alen_q;
        dma_axi_req_o.size  = size_q;
        dma_axi_req_o.strb  = strb_q;
        dma_axi_req_o.valid = (state_q == REQ);
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_dma_streamer.sv
// Directed self-checking bench for dma_streamer request splitting.
module tb_dma_streamer;
    import dma_pkg::*;

    logic            clk;
    logic            rstn;
    logic            dma_go_i;
    logic [31:0]     desc_addr_i;
    logic [31:0]     desc_num_bytes_i;
    logic            dma_active_i;
    logic            clear_dma_i;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            busy_o;
    logic            done_o;

    int checks;
    int errors;

    localparam logic [63:0] ONES = {64{1'b1}};

    dma_streamer #(
        .ADDR_W    (32),
        .DATA_W    (512),
        .MAX_BEATS (16),
        .BOUNDARY  (4096)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .dma_go_i         (dma_go_i),
        .desc_addr_i      (desc_addr_i),
        .desc_num_bytes_i (desc_num_bytes_i),
        .dma_active_i     (dma_active_i),
        .clear_dma_i      (clear_dma_i),
        .dma_axi_req_o    (req),
        .dma_axi_resp_i   (resp),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge.
    task automatic do_go(input logic [31:0] a, input logic [31:0] n);
        desc_addr_i      = a;
        desc_num_bytes_i = n;
        dma_go_i         = 1'b1;
        @(negedge clk);
        dma_go_i         = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req.valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_clear();
        clear_dma_i = 1'b1;
        @(negedge clk);
        clear_dma_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%h busy=%b done=%b, required all zero", req, busy_o, done_o);
        end
    endtask

    task automatic run_seq(input string name, input logic [31:0] a, input logic [31:0] n,
                           input int cnt, input logic [31:0] ea[4], input logic [7:0] el[4],
                           input logic [2:0] es[4], input logic [63:0] eb[4]);
        bit ok;
        do_go(a, n);
        for (int k = 0; k < cnt; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s req%0d: valid timeout, required valid=1", name, k);
            end else begin
                checks++;
                if (req.addr !== ea[k] || req.alen !== el[k] || req.size !== es[k] ||
                    req.strb !== eb[k] || done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req%0d: addr=%h alen=%0d size=%0d strb=%h done=%b, required addr=%h alen=%0d size=%0d strb=%h done=0",
                             name, k, req.addr, req.alen, req.size, req.strb, done_o,
                             ea[k], el[k], es[k], eb[k]);
                end
            end
            @(negedge clk);
            if (k < cnt - 1) begin
                checks++;
                if (req.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s calc_gap%0d: valid=%b, required 0", name, k, req.valid);
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || req.valid !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s done: done=%b valid=%b busy=%b, required done=1 valid=0 busy=1",
                     name, done_o, req.valid, busy_o);
        end
        do_clear();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: done=%b busy=%b, required 0 0", name, done_o, busy_o);
        end
    endtask

    task automatic test_aligned();
        run_seq("aligned", 32'h1000, 256, 1,
                '{32'h1000, 0, 0, 0}, '{8'd3, 0, 0, 0}, '{3'd6, 0, 0, 0}, '{ONES, 0, 0, 0});
    endtask

    task automatic test_cross_4k();
        run_seq("cross4k", 32'h0F80, 256, 2,
                '{32'h0F80, 32'h1000, 0, 0}, '{8'd1, 8'd1, 0, 0},
                '{3'd6, 3'd6, 0, 0}, '{ONES, ONES, 0, 0});
    endtask

    task automatic test_unaligned();
        run_seq("unaligned", 32'h1003, 8, 4,
                '{32'h1003, 32'h1004, 32'h1008, 32'h100A}, '{8'd0, 8'd0, 8'd0, 8'd0},
                '{3'd0, 3'd2, 3'd1, 3'd0},
                '{64'h8, 64'hF0, 64'h300, 64'h400});
    endtask

    task automatic test_max_split();
        run_seq("maxsplit", 32'h0, 4096, 4,
                '{32'h000, 32'h400, 32'h800, 32'hC00}, '{8'd15, 8'd15, 8'd15, 8'd15},
                '{3'd6, 3'd6, 3'd6, 3'd6}, '{ONES, ONES, ONES, ONES});
    endtask

    task automatic test_backpressure();
        bit ok;
        resp.ready = 1'b0;
        do_go(32'h2000, 128);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_start: valid timeout, required valid=1");
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req.valid !== 1'b1 || req.addr !== 32'h2000 || req.alen !== 8'd1 ||
                req.size !== 3'd6 || req.strb !== ONES || done_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b addr=%h alen=%0d size=%0d done=%b, required 1 2000 1 6 0",
                         c, req.valid, req.addr, req.alen, req.size, done_o);
            end
        end
        resp.ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || req.valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: done=%b valid=%b, required 1 0", done_o, req.valid);
        end
        do_clear();
    endtask

    task automatic test_abort();
        bit ok;
        resp.ready = 1'b0;
        do_go(32'h3000, 64);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_start: valid timeout, required valid=1");
        end
        dma_active_i = 1'b0;
        @(negedge clk);
        checks++;
        if (req.valid !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort: valid=%b busy=%b done=%b, required 0 0 0", req.valid, busy_o, done_o);
        end
        dma_active_i = 1'b1;
        resp.ready   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        do_go(32'h4000, 0);
        checks++;
        if (done_o !== 1'b1 || req.valid !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: done=%b valid=%b busy=%b, required 1 0 1", done_o, req.valid, busy_o);
        end
        // go together with clear in DONE: clear wins
        dma_go_i    = 1'b1;
        clear_dma_i = 1'b1;
        @(negedge clk);
        dma_go_i    = 1'b0;
        clear_dma_i = 1'b0;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || req.valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: done=%b busy=%b valid=%b, required 0 0 0", done_o, busy_o, req.valid);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rstn             = 1'b0;
        dma_go_i         = 1'b0;
        desc_addr_i      = '0;
        desc_num_bytes_i = '0;
        dma_active_i     = 1'b1;
        clear_dma_i      = 1'b0;
        resp.ready       = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_aligned();
        test_cross_4k();
        test_unaligned();
        test_max_split();
        test_backpressure();
        test_abort();
        test_zero_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
